// File: rtl/sm83_pkg.sv
// Shared SM83 bus types plus the OAM DMA constants reused by the DMA engine,
// the PPU and the bus arbiter.
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } dma_state_t;

  localparam addr_t OAM_BASE    = 16'hFE00;
  localparam int    OAM_DMA_LEN = 160;

  // Pages E0-FF are the echo of work RAM, so the DMA reads them from C0-DF.
  function automatic data_t dma_src_page(input data_t page);
    return (page >= 8'hE0) ? data_t'(page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/mock_mem.sv
// 64 KiB byte array with a combinational read port and a registered write port.
// ROM instances ignore the write port; their contents are loaded externally.
module mock_mem
  import sm83_pkg::*;
#(
  parameter bit IS_ROM = 1'b0
) (
  input  logic  i_clk,
  input  addr_t i_r_addr,
  output data_t o_r_data,
  input  logic  i_wen,
  input  addr_t i_w_addr,
  input  data_t i_w_data
);

  data_t r_mem [0:65535];

  assign o_r_data = r_mem[i_r_addr];

  generate
    if (!IS_ROM) begin : g_ram
      always_ff @(posedge i_clk) begin
        if (i_wen) begin
          r_mem[i_w_addr] <= i_w_data;
        end
      end
    end else begin : g_rom
      logic w_unused;
      assign w_unused = ^{i_clk, i_wen, i_w_addr, i_w_data};
    end
  endgenerate

endmodule

// File: rtl/oam_dma.sv
// OAM DMA: a write to FF46 copies DMA_LEN bytes from page XX00 to OAM, one byte per
// M-cycle after a one M-cycle setup; a new write restarts it. No backpressure.
module oam_dma
  import sm83_pkg::*;
#(
  parameter int    DMA_LEN   = OAM_DMA_LEN,
  parameter int    MCYC_CLKS = 4,
  parameter addr_t OAM_BASE  = sm83_pkg::OAM_BASE
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_reg_wen,
  input  data_t i_reg_wdata,
  output data_t o_reg_rdata,
  output addr_t o_src_r_addr,
  input  data_t i_src_r_data,
  output logic  o_oam_wen,
  output addr_t o_oam_w_addr,
  output data_t o_oam_w_data,
  output logic  o_busy
);

  localparam int              PH_W     = $clog2(MCYC_CLKS);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(MCYC_CLKS - 1);
  localparam logic [7:0]      IDX_LAST = 8'(DMA_LEN - 1);

  dma_state_t      r_state;
  data_t           r_page;
  logic [7:0]      r_idx;
  logic [PH_W-1:0] r_phase;
  data_t           r_reg_rdata;

  dma_state_t      w_state_nxt;
  data_t           w_page_nxt;
  logic [7:0]      w_idx_nxt;
  logic [PH_W-1:0] w_phase_nxt;
  data_t           w_reg_rdata_nxt;
  logic            w_last_ph;
  logic            w_wr;
  data_t           w_eff_page;

  assign w_last_ph  = (r_phase == PH_LAST);
  assign w_wr       = (r_state == XFER) && w_last_ph;
  assign w_eff_page = dma_src_page(r_page);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_page      <= '0;
      r_idx       <= '0;
      r_phase     <= '0;
      r_reg_rdata <= 8'hFF;
    end else begin
      r_state     <= w_state_nxt;
      r_page      <= w_page_nxt;
      r_idx       <= w_idx_nxt;
      r_phase     <= w_phase_nxt;
      r_reg_rdata <= w_reg_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_page_nxt      = r_page;
    w_idx_nxt       = r_idx;
    w_phase_nxt     = r_phase;
    w_reg_rdata_nxt = r_reg_rdata;

    case (r_state)
      IDLE: begin
      end
      START: begin
        w_phase_nxt = w_last_ph ? '0 : r_phase + PH_W'(1);
        if (w_last_ph) begin
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        w_phase_nxt = w_last_ph ? '0 : r_phase + PH_W'(1);
        if (w_last_ph) begin
          if (r_idx == IDX_LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A write in any state (re)starts from the setup M-cycle.
    if (i_reg_wen) begin
      w_page_nxt      = i_reg_wdata;
      w_reg_rdata_nxt = i_reg_wdata;
      w_idx_nxt       = '0;
      w_phase_nxt     = '0;
      w_state_nxt     = START;
    end
  end

  always_comb begin
    o_busy       = (r_state != IDLE);
    o_reg_rdata  = r_reg_rdata;
    o_src_r_addr = (r_state == XFER) ? {w_eff_page, r_idx} : '0;
    o_oam_wen    = w_wr;
    o_oam_w_addr = w_wr ? OAM_BASE + addr_t'(r_idx) : '0;
    o_oam_w_data = w_wr ? i_src_r_data : '0;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized scoreboard bench for oam_dma: a timing model of transfers predicts
// busy, source address and every OAM write; a monitor compares each cycle.
module tb_oam_dma;
  import sm83_pkg::*;

  localparam int LEN  = 160;
  localparam int MC   = 4;
  localparam int SPAN = MC * (LEN + 1);

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  reg_wen = 1'b0;
  data_t reg_wdata = '0;
  data_t reg_rdata, src_r_data, oam_w_data, oam_rdata;
  addr_t src_r_addr, oam_w_addr;
  addr_t oam_raddr = '0;
  logic  oam_wen, busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int wen_cnt = 0;
  bit chk_en = 1'b0;

  typedef struct { int t0; int tend; data_t pg; } seg_t;
  typedef struct { int cyc; int idx; data_t dat; } wr_t;

  seg_t  segs[$];
  wr_t   exp_q[$];
  data_t src_img [0:65535];
  data_t oam_exp [0:LEN-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oam_dma #(.DMA_LEN(LEN), .MCYC_CLKS(MC), .OAM_BASE(16'hFE00)) dut (
    .i_clk(clk), .i_rst(rst), .i_reg_wen(reg_wen), .i_reg_wdata(reg_wdata),
    .o_reg_rdata(reg_rdata), .o_src_r_addr(src_r_addr), .i_src_r_data(src_r_data),
    .o_oam_wen(oam_wen), .o_oam_w_addr(oam_w_addr), .o_oam_w_data(oam_w_data),
    .o_busy(busy)
  );

  mock_mem #(.IS_ROM(1'b1)) u_src (
    .i_clk(clk), .i_r_addr(src_r_addr), .o_r_data(src_r_data),
    .i_wen(1'b0), .i_w_addr(16'h0000), .i_w_data(8'h00)
  );

  mock_mem #(.IS_ROM(1'b0)) u_oam (
    .i_clk(clk), .i_r_addr(oam_raddr), .o_r_data(oam_rdata),
    .i_wen(oam_wen), .i_w_addr(oam_w_addr), .i_w_data(oam_w_data)
  );

  function automatic data_t eff_pg(input data_t p);
    if (p >= 8'hE0) return data_t'(p - 8'h20);
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  // Anything sampled at the end of cycle c stops the current transfer after cycle c.
  task automatic cut(input int c);
    seg_t s;
    if (segs.size() > 0) begin
      s = segs.pop_back();
      if (s.tend > c) s.tend = c;
      segs.push_back(s);
    end
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > c) void'(exp_q.pop_back());
  endtask

  task automatic start_xfer(input data_t p);
    seg_t s;
    wr_t  w;
    cut(cyc);
    s.t0 = cyc; s.tend = cyc + SPAN; s.pg = p;
    segs.push_back(s);
    for (int i = 0; i < LEN; i++) begin
      w.cyc = cyc + MC * (i + 2);
      w.idx = i;
      w.dat = src_img[{eff_pg(p), 8'(i)}];
      exp_q.push_back(w);
    end
    reg_wen = 1'b1; reg_wdata = p;
    step();
    reg_wen = 1'b0;
  endtask

  task automatic do_reset();
    cut(cyc);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_oam();
    for (int k = 0; k < LEN; k++) begin
      oam_raddr = 16'hFE00 + 16'(k);
      #1;
      chk("oam_content", 32'(oam_rdata), 32'(oam_exp[k]));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin : mon
      logic  exp_busy;
      addr_t exp_src;
      logic  exp_w;
      wr_t   e;
      exp_busy = 1'b0;
      exp_src  = '0;
      foreach (segs[k]) begin
        if (cyc > segs[k].t0 && cyc <= segs[k].tend) begin
          exp_busy = 1'b1;
          if (cyc > segs[k].t0 + MC)
            exp_src = {eff_pg(segs[k].pg), 8'((cyc - segs[k].t0 - MC - 1) / MC)};
        end
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("src_r_addr", 32'(src_r_addr), 32'(exp_src));
      exp_w = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("oam_wen", 32'(oam_wen), 32'(exp_w));
      if (exp_w) begin
        e = exp_q.pop_front();
        oam_exp[e.idx] = e.dat;
        chk("oam_w_addr", 32'(oam_w_addr), 32'(16'hFE00 + 16'(e.idx)));
        chk("oam_w_data", 32'(oam_w_data), 32'(e.dat));
      end else begin
        chk("oam_w_addr_idle", 32'(oam_w_addr), 32'h0);
        chk("oam_w_data_idle", 32'(oam_w_data), 32'h0);
      end
      if (oam_wen) wen_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int    b, w0, gap;
    data_t p, last;

    for (int a = 0; a < 65536; a++) src_img[a] = data_t'($urandom);
    for (int k = 0; k < 256; k++) src_img[16'hC000 + k] = data_t'(k) ^ 8'h5A;
    for (int a = 0; a < 65536; a++) u_src.r_mem[a] = src_img[a];

    // Reset values, then a long idle stretch with no register writes.
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_reg_rdata", 32'(reg_rdata), 32'hFF);
    wait_until(cyc + 1000);
    chk("idle_reg_rdata", 32'(reg_rdata), 32'hFF);
    chk("idle_no_wen", 32'(wen_cnt), 32'd0);

    // Basic transfer from page C0.
    b = cyc; w0 = wen_cnt;
    start_xfer(8'hC0);
    wait_until(b + 8);
    chk("first_wen", 32'(oam_wen), 32'd1);
    chk("first_addr", 32'(oam_w_addr), 32'hFE00);
    chk("first_src", 32'(src_r_addr), 32'hC000);
    wait_until(b + SPAN);
    chk("last_wen", 32'(oam_wen), 32'd1);
    chk("last_addr", 32'(oam_w_addr), 32'hFE9F);
    wait_until(b + SPAN + 1);
    chk("basic_busy_end", 32'(busy), 32'd0);
    chk("basic_wen_count", 32'(wen_cnt - w0), 32'd160);
    chk("basic_reg_rdata", 32'(reg_rdata), 32'hC0);
    for (int k = 0; k < LEN; k++) begin
      oam_raddr = 16'hFE00 + 16'(k);
      #1;
      chk("basic_oam_pattern", 32'(oam_rdata), 32'(data_t'(k) ^ 8'h5A));
    end

    // Echo page E1, then a back-to-back start on its last write cycle.
    b = cyc;
    start_xfer(8'hE1);
    wait_until(b + 5);
    chk("echo_src", 32'(src_r_addr), 32'hC100);
    wait_until(b + SPAN);
    start_xfer(8'hD5);
    wait_until(b + 2 * SPAN + 2);
    chk("b2b_reg_rdata", 32'(reg_rdata), 32'hD5);
    chk_oam();

    // Restart mid-transfer: C0, then D0 at cycle 100.
    b = cyc;
    start_xfer(8'hC0);
    wait_until(b + 100);
    start_xfer(8'hD0);
    wait_until(b + 102);
    for (int k = 0; k < 23; k++) begin
      oam_raddr = 16'hFE00 + 16'(k);
      #1;
      chk("restart_old_bytes", 32'(oam_rdata), 32'(data_t'(k) ^ 8'h5A));
    end
    wait_until(b + 100 + SPAN + 2);
    chk("restart_reg_rdata", 32'(reg_rdata), 32'hD0);
    chk_oam();

    // Reset mid-transfer at cycle 50.
    b = cyc;
    start_xfer(8'hC3);
    wait_until(b + 50);
    do_reset();
    chk("abort_reg_rdata", 32'(reg_rdata), 32'hFF);
    chk("abort_busy", 32'(busy), 32'd0);
    w0 = wen_cnt;
    wait_until(b + 750);
    chk("abort_no_wen", 32'(wen_cnt - w0), 32'd0);
    chk_oam();

    // Reset and register write in the same cycle: reset wins.
    cut(cyc);
    rst = 1'b1; reg_wen = 1'b1; reg_wdata = 8'h12;
    step();
    rst = 1'b0; reg_wen = 1'b0;
    wait_until(cyc + 20);
    chk("rst_beats_wen_rdata", 32'(reg_rdata), 32'hFF);
    chk("rst_beats_wen_busy", 32'(busy), 32'd0);

    // Random pages with optional restarts at random points.
    for (int it = 0; it < 4; it++) begin
      b = cyc;
      p = data_t'($urandom);
      start_xfer(p);
      last = p;
      gap = $urandom_range(1, SPAN + 8);
      wait_until(b + gap);
      if ($urandom_range(0, 1) == 1) begin
        p = data_t'($urandom);
        start_xfer(p);
        last = p;
      end
      wait_until(cyc + SPAN + 4);
      chk("rand_reg_rdata", 32'(reg_rdata), 32'(last));
      chk_oam();
    end

    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
